// File: rtl/tile_pkg.sv
// tile_pkg: shared constants, state encoding and LFSR/row helpers for the
// tile generator.
//   LANES      - number of tile lanes (one bit per lane in a row)
//   LANE0..2   - one-hot lane codes, lane0 in the MSB
//   LFSR_TAPS  - Galois feedback mask for the 8-bit right-shifting LFSR
//   state_e    - game FSM encoding (IDLE=0, RUN=1, PAUSE=2, OVER=3)
package tile_pkg;

    localparam int LANES = 3;

    localparam logic [LANES-1:0] LANE0 = 3'b100;
    localparam logic [LANES-1:0] LANE1 = 3'b010;
    localparam logic [LANES-1:0] LANE2 = 3'b001;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    // One Galois step: shift right, fold the taps in when a 1 falls out.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 8'h00);
    endfunction

    // An all-zero LFSR would lock up, so a zero seed becomes 1.
    function automatic logic [7:0] seed_fix(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    // Map an LFSR value to a one-hot row. Code 3 splits between the two
    // outer lanes so the middle lane is not over-represented.
    function automatic logic [LANES-1:0] row_of(input logic [7:0] v);
        case (v[1:0])
            2'd0:    return LANE0;
            2'd1:    return LANE1;
            2'd2:    return LANE2;
            default: return v[2] ? LANE0 : LANE2;
        endcase
    endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Galois LFSR with synchronous load.
//   div_clk - clock
//   rst     - asynchronous active-low reset, loads the (fixed) seed
//   load    - reload seed; wins over adv
//   adv     - advance one step
//   seed    - reload value (0 is replaced by 1)
//   q       - current LFSR value
module lfsr8 import tile_pkg::*; (
    input  logic       div_clk,
    input  logic       rst,
    input  logic       load,
    input  logic       adv,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load)     q_d = seed_fix(seed);
        else if (adv) q_d = lfsr_next(q_q);
    end

    always_ff @(posedge div_clk or negedge rst) begin
        if (!rst) q_q <= seed_fix(seed);
        else      q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/tile_gen.sv
// tile_gen: pseudo-random tile row generator with a ROWS-deep scroll buffer,
// feeding the per-window scoring stage.
//   div_clk   - game clock
//   rst       - asynchronous active-low reset
//   start_n   - start/restart button, active-low, asynchronous
//   pause     - level, freezes scrolling while high
//   miss      - one-cycle pulse from downstream, ends the game
//   data      - bottom row (lane0 in bit 2), zero outside RUN/PAUSE
//   rows_flat - whole buffer, row 0 (top) in the MSBs
//   step      - one-cycle pulse after each buffer shift
//   row_count - rows emitted since start, saturating
//   state     - game state (IDLE/RUN/PAUSE/OVER)
module tile_gen import tile_pkg::*; #(
    parameter int unsigned WINDOW = 1000,
    parameter int unsigned ROWS   = 4,
    parameter logic [7:0]  SEED   = 8'hA5
) (
    input  logic                  div_clk,
    input  logic                  rst,
    input  logic                  start_n,
    input  logic                  pause,
    input  logic                  miss,
    output logic [LANES-1:0]      data,
    output logic [LANES*ROWS-1:0] rows_flat,
    output logic                  step,
    output logic [15:0]           row_count,
    output logic [1:0]            state
);

    localparam int CW = (WINDOW > 0) ? $clog2(WINDOW + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW);

    // start_n: two synchronizer flops plus one history flop for the edge.
    logic sync1_q, sync2_q, sync3_q;
    logic start_evt;

    always_ff @(posedge div_clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= start_n;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign start_evt = sync3_q & ~sync2_q;

    // Game FSM
    state_e state_q, state_d;

    always_ff @(posedge div_clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_evt) state_d = ST_RUN;
            ST_RUN:   if (miss) state_d = ST_OVER;
                      else if (pause) state_d = ST_PAUSE;
            ST_PAUSE: if (miss) state_d = ST_OVER;
                      else if (!pause) state_d = ST_RUN;
            ST_OVER:  if (start_evt) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    logic                        playing, restart, adv, shift;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [ROWS-1:0][LANES-1:0]  rows_q, rows_d;
    logic [15:0]                 rc_q, rc_d;
    logic                        step_q;
    logic [7:0]                  lfsr_q;

    // The counter advances on every edge whose next state is RUN coming from
    // RUN or PAUSE: pause freezes it on the very edge it is raised, and the
    // release edge already counts, so a paused window loses nothing.
    always_comb begin
        playing = (state_q == ST_RUN) || (state_q == ST_PAUSE);
        restart = ((state_q == ST_IDLE) || (state_q == ST_OVER)) && start_evt;
        adv     = playing && !pause && !miss;
        shift   = adv && (cnt_q == CNT_LAST);
        data    = playing ? rows_q[ROWS-1] : '0;
    end

    always_comb begin
        cnt_d  = cnt_q;
        rows_d = rows_q;
        rc_d   = rc_q;
        if (restart) begin
            cnt_d  = '0;
            rows_d = '0;
            rc_d   = '0;
        end else if (shift) begin
            cnt_d = '0;
            for (int i = ROWS - 1; i > 0; i--) rows_d[i] = rows_q[i-1];
            // The new row uses the value the LFSR steps to on this edge.
            rows_d[0] = row_of(lfsr_next(lfsr_q));
            if (rc_q != 16'hFFFF) rc_d = rc_q + 16'd1;
        end else if (adv) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge div_clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            rows_q <= '0;
            rc_q   <= '0;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rows_q <= rows_d;
            rc_q   <= rc_d;
            step_q <= shift;
        end
    end

    lfsr8 u_lfsr (
        .div_clk (div_clk),
        .rst     (rst),
        .load    (restart),
        .adv     (shift),
        .seed    (SEED),
        .q       (lfsr_q)
    );

    for (genvar g = 0; g < ROWS; g++) begin : g_flat
        assign rows_flat[LANES*(ROWS-1-g) +: LANES] = rows_q[g];
    end

    assign step      = step_q;
    assign row_count = rc_q;
    assign state     = state_q;

endmodule

// File: tb/tb_tile_gen.sv
// Testbench for tile_gen: directed sequences with constant expectations, a
// per-window expectation table, randomized play against a behavioural model,
// and a parallel WINDOW=0 instance that runs row_count into saturation.
module tb_tile_gen;

    localparam int         W  = 7;
    localparam int         R  = 4;
    localparam logic [7:0] SD = 8'hA5;

    logic          div_clk = 1'b0;
    logic          rst = 1'b0, start_n = 1'b1, pause = 1'b0, miss = 1'b0;
    logic [2:0]    data;
    logic [3*R-1:0] rows_flat;
    logic          step;
    logic [15:0]   row_count;
    logic [1:0]    state;

    logic          b_rst = 1'b0, b_start_n = 1'b1;
    logic [2:0]    b_data;
    logic [5:0]    b_rows;
    logic          b_step;
    logic [15:0]   b_rc;
    logic [1:0]    b_state;

    tile_gen #(.WINDOW(W), .ROWS(R), .SEED(SD)) dut (
        .div_clk(div_clk), .rst(rst), .start_n(start_n), .pause(pause), .miss(miss),
        .data(data), .rows_flat(rows_flat), .step(step), .row_count(row_count), .state(state)
    );

    tile_gen #(.WINDOW(0), .ROWS(2), .SEED(8'h00)) dut_b (
        .div_clk(div_clk), .rst(b_rst), .start_n(b_start_n), .pause(1'b0), .miss(1'b0),
        .data(b_data), .rows_flat(b_rows), .step(b_step), .row_count(b_rc), .state(b_state)
    );

    always #5 div_clk = ~div_clk;

    int tests = 0, fails = 0, cyc = 0, b_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: game state as 0..3, scroll buffer as a queue of
    // lane codes with the top row at the front, start button as a history
    // of the last three sampled levels.
    int m_state, m_cnt, m_rc, m_lf, m_step;
    int m_rows[$];
    int s1, s2, s3;

    function automatic int row_for(int v);
        case (v % 4)
            0:       return 4;
            1:       return 2;
            2:       return 1;
            default: return ((v / 4) % 2 == 1) ? 4 : 1;
        endcase
    endfunction

    task automatic m_reset();
        m_state = 0; m_cnt = 0; m_rc = 0; m_lf = SD; m_step = 0;
        m_rows = {};
        for (int i = 0; i < R; i++) m_rows.push_back(0);
        s1 = 1; s2 = 1; s3 = 1;
    endtask

    task automatic m_edge();
        bit evt, play, adv;
        evt  = (s3 == 1) && (s2 == 0);
        play = (m_state == 1) || (m_state == 2);
        adv  = play && !pause && !miss;
        m_step = 0;
        if ((m_state == 0 || m_state == 3) && evt) begin
            m_cnt = 0; m_lf = SD; m_rc = 0;
            for (int i = 0; i < R; i++) m_rows[i] = 0;
        end else if (adv && m_cnt == W) begin
            m_cnt = 0;
            m_lf = (m_lf % 2 == 1) ? ((m_lf / 2) ^ 184) : (m_lf / 2);
            m_rows.push_front(row_for(m_lf));
            void'(m_rows.pop_back());
            if (m_rc < 65535) m_rc++;
            m_step = 1;
        end else if (adv) begin
            m_cnt++;
        end
        if (play && miss)                           m_state = 3;
        else if ((m_state == 0 || m_state == 3) && evt) m_state = 1;
        else if (m_state == 1 && pause)             m_state = 2;
        else if (m_state == 2 && !pause)            m_state = 1;
        s3 = s2; s2 = s1; s1 = start_n;
    endtask

    task automatic cmp_model();
        int flat, md;
        flat = 0;
        for (int i = 0; i < R; i++) flat = flat * 8 + m_rows[i];
        md = (m_state == 1 || m_state == 2) ? m_rows[R-1] : 0;
        chk("model_state", 32'(state), 32'(m_state));
        chk("model_data", 32'(data), 32'(md));
        chk("model_rows", 32'(rows_flat), 32'(flat));
        chk("model_step", 32'(step), 32'(m_step));
        chk("model_rc", 32'(row_count), 32'(m_rc));
    endtask

    task automatic tick();
        @(posedge div_clk);
        cyc++;
        if (rst) m_edge(); else m_reset();
        #1;
        cmp_model();
    endtask

    task automatic wait_step(input int maxc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!step && n < maxc);
    endtask

    always @(negedge div_clk)
        if (!(b_data == 3'b000 || b_data == 3'b001 || b_data == 3'b010 || b_data == 3'b100))
            b_bad++;

    typedef struct {
        int         gap;
        logic [2:0] top;
        logic [2:0] dat;
        logic [15:0] rc;
    } win_t;

    initial begin
        win_t wt[4];
        int n, st;
        logic [3*R-1:0] saved;

        wt[0] = '{6, 3'b001, 3'b000, 16'd1};
        wt[1] = '{8, 3'b010, 3'b000, 16'd2};
        wt[2] = '{8, 3'b001, 3'b000, 16'd3};
        wt[3] = '{8, 3'b010, 3'b001, 16'd4};

        m_reset();
        repeat (3) tick();
        chk("rst_data", 32'(data), 0);
        chk("rst_rows", 32'(rows_flat), 0);
        chk("rst_step", 32'(step), 0);
        chk("rst_rc", 32'(row_count), 0);
        chk("rst_state", 32'(state), 0);
        rst = 1'b1; b_rst = 1'b1;
        tick();

        // start: RUN on the 3rd edge after start_n is first sampled low
        start_n = 1'b0; b_start_n = 1'b0;
        tick(); tick();
        chk("idle_before_evt", 32'(state), 0);
        tick();
        chk("run_on_3rd", 32'(state), 1);
        tick();
        chk("b_seed0_row", 32'(b_rows[5:3]), 32'(3'b100));
        tick();
        chk("start_state", 32'(state), 1);
        chk("start_data", 32'(data), 0);
        chk("start_rows", 32'(rows_flat), 0);
        chk("start_rc", 32'(row_count), 0);
        start_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            wait_step(12, n);
            chk("win_gap", 32'(n), 32'(wt[i].gap));
            chk("win_top", 32'(rows_flat[3*R-1 -: 3]), 32'(wt[i].top));
            chk("win_data", 32'(data), 32'(wt[i].dat));
            chk("win_rc", 32'(row_count), 32'(wt[i].rc));
        end
        chk("win_flat", 32'(rows_flat), 32'(12'b010_001_010_001));

        // pause with cnt at 3
        repeat (3) tick();
        pause = 1'b1;
        st = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step) st++;
        end
        chk("pause_nostep", 32'(st), 0);
        chk("pause_state", 32'(state), 2);
        pause = 1'b0;
        wait_step(10, n);
        chk("resume_gap", 32'(n), 5);
        chk("resume_state", 32'(state), 1);

        // miss ends the game, buffer frozen
        repeat (2) tick();
        saved = rows_flat;
        miss = 1'b1; tick(); miss = 1'b0;
        chk("over_state", 32'(state), 3);
        chk("over_data", 32'(data), 0);
        chk("over_rows", 32'(rows_flat), 32'(saved));
        st = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step) st++;
        end
        chk("over_nostep", 32'(st), 0);
        chk("over_rows_hold", 32'(rows_flat), 32'(saved));
        start_n = 1'b0;
        repeat (3) tick();
        chk("restart_state", 32'(state), 1);
        chk("restart_rc", 32'(row_count), 0);
        chk("restart_rows", 32'(rows_flat), 0);
        start_n = 1'b1;
        wait_step(12, n);
        chk("restart_gap", 32'(n), 8);
        chk("restart_top", 32'(rows_flat[3*R-1 -: 3]), 32'(3'b001));
        chk("restart_rc1", 32'(row_count), 1);

        // asynchronous reset mid-window (cnt=5)
        repeat (5) tick();
        rst = 1'b0;
        #1;
        m_reset();
        chk("arst_data", 32'(data), 0);
        chk("arst_rows", 32'(rows_flat), 0);
        chk("arst_step", 32'(step), 0);
        chk("arst_rc", 32'(row_count), 0);
        chk("arst_state", 32'(state), 0);
        repeat (2) tick();
        rst = 1'b1;
        st = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step) st++;
        end
        chk("post_rst_nostep", 32'(st), 0);
        chk("post_rst_idle", 32'(state), 0);

        // miss and start_evt on the same edge while running
        start_n = 1'b0;
        repeat (3) tick();
        chk("run_again", 32'(state), 1);
        start_n = 1'b1;
        repeat (3) tick();
        start_n = 1'b0;
        tick(); tick();
        miss = 1'b1; tick(); miss = 1'b0;
        chk("miss_wins", 32'(state), 3);
        repeat (3) tick();
        chk("single_evt", 32'(state), 3);
        start_n = 1'b1;

        // randomized play checked against the model every cycle
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) start_n = ~start_n;
            if ($urandom_range(0, 9) == 0)  pause = ~pause;
            miss = ($urandom_range(0, 99) == 0);
            tick();
        end
        start_n = 1'b1; pause = 1'b0; miss = 1'b0;

        // let the WINDOW=0 instance run into saturation
        while (cyc < 65700) tick();
        chk("b_sat", 32'(b_rc), 32'(16'hFFFF));
        chk("b_state", 32'(b_state), 1);
        chk("b_onehot", 32'(b_bad), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
